// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encoding and byte helper for the memory controller.
package mem_ctrl_pkg;

   localparam int unsigned ADDR_WID        = 32;
   localparam int unsigned DATA_WID        = 32;
   localparam int unsigned BYTE_WID        = 8;
   localparam int unsigned ICACHE_LINE_WID = 512;
   localparam int unsigned LINE_BYTES      = ICACHE_LINE_WID / BYTE_WID;
   localparam int unsigned CNT_WID         = 7;
   localparam int unsigned IDX_WID         = 6;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIfetch = 2'd1,
      StLoad   = 2'd2,
      StStore  = 2'd3
   } state_e;

   function automatic logic [BYTE_WID-1:0] get_byte(input logic [DATA_WID-1:0] w,
                                                    input logic [1:0]          idx);
      return w[{idx, 3'b000} +: BYTE_WID];
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating line fetches and LSB loads/stores.
// Optional MEM_CTRL_IO_STALL_EN holds store bytes to the IO window while the UART is full.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       rollback,
   input  logic [BYTE_WID-1:0]        mem_din,
   output logic [BYTE_WID-1:0]        mem_dout,
   output logic [ADDR_WID-1:0]        mem_a,
   output logic                       mem_wr,
   input  logic                       io_buffer_full,
   input  logic                       if_en,
   input  logic [ADDR_WID-1:0]        if_pc,
   output logic                       if_done,
   output logic [ICACHE_LINE_WID-1:0] if_data,
   input  logic                       lsb_en,
   input  logic                       lsb_wr,
   input  logic [ADDR_WID-1:0]        lsb_addr,
   input  logic [2:0]                 lsb_len,
   input  logic [DATA_WID-1:0]        lsb_w_data,
   output logic                       lsb_done,
   output logic [DATA_WID-1:0]        lsb_r_data
);

   state_e                     state_q, state_d;
   logic [CNT_WID-1:0]         cnt_q, cnt_d;
   logic [CNT_WID-1:0]         n_q, n_d;
   logic [ADDR_WID-1:0]        base_q, base_d;
   logic [DATA_WID-1:0]        wdata_q, wdata_d;
   logic [ADDR_WID-1:0]        mem_a_q, mem_a_d;
   logic [BYTE_WID-1:0]        mem_dout_q, mem_dout_d;
   logic                       wr_q, wr_d;
   logic                       if_done_q, if_done_d;
   logic                       lsb_done_q, lsb_done_d;
   logic [ICACHE_LINE_WID-1:0] if_data_q, if_data_d;
   logic [DATA_WID-1:0]        lsb_r_data_q, lsb_r_data_d;
   logic [ICACHE_LINE_WID-1:0] buf_q, buf_d, buf_cap;
   logic                       rd_vld_q, rd_vld_d;
   logic [IDX_WID-1:0]         rd_idx_q, rd_idx_d;
   logic                       stall;

`ifdef MEM_CTRL_IO_STALL_EN
   assign stall = (state_q == StStore) && (mem_a_q[17:16] == 2'b11) && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = io_buffer_full;
   assign stall     = 1'b0;
`endif

   // RAM data lags its address by a cycle, so a byte addressed in an active cycle is
   // captured in the following cycle even if rdy has dropped meanwhile.
   always_comb begin
      buf_cap = buf_q;
      if (rd_vld_q) begin
         buf_cap[{rd_idx_q, 3'b000} +: BYTE_WID] = mem_din;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      n_d          = n_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      wr_d         = wr_q;
      if_done_d    = if_done_q;
      lsb_done_d   = lsb_done_q;
      if_data_d    = if_data_q;
      lsb_r_data_d = lsb_r_data_q;
      buf_d        = buf_cap;
      rd_vld_d     = 1'b0;
      rd_idx_d     = rd_idx_q;

      if (rdy) begin
         if_done_d  = 1'b0;
         lsb_done_d = 1'b0;
         unique case (state_q)
            StIdle: begin
               // A done pulse marks a cycle that must stay idle.
               if (!if_done_q && !lsb_done_q) begin
                  if (lsb_en) begin
                     base_d  = lsb_addr;
                     n_d     = {4'b0000, lsb_len};
                     wdata_d = lsb_w_data;
                     cnt_d   = '0;
                     mem_a_d = lsb_addr;
                     buf_d   = '0;
                     if (lsb_wr) begin
                        state_d    = StStore;
                        mem_dout_d = lsb_w_data[BYTE_WID-1:0];
                        wr_d       = 1'b1;
                     end else begin
                        state_d = StLoad;
                     end
                  end else if (if_en) begin
                     base_d  = if_pc;
                     n_d     = CNT_WID'(LINE_BYTES);
                     cnt_d   = '0;
                     mem_a_d = if_pc;
                     buf_d   = '0;
                     state_d = StIfetch;
                  end
               end
            end
            StIfetch, StLoad: begin
               if (rollback) begin
                  state_d = StIdle;
               end else if (cnt_q == n_q) begin
                  state_d = StIdle;
                  if (state_q == StIfetch) begin
                     if_done_d = 1'b1;
                     if_data_d = buf_cap;
                  end else begin
                     lsb_done_d   = 1'b1;
                     lsb_r_data_d = buf_cap[DATA_WID-1:0];
                  end
               end else begin
                  rd_vld_d = 1'b1;
                  rd_idx_d = cnt_q[IDX_WID-1:0];
                  cnt_d    = cnt_q + 7'd1;
                  if ((cnt_q + 7'd1) < n_q) begin
                     mem_a_d = base_q + {25'b0, cnt_q} + 32'd1;
                  end
               end
            end
            StStore: begin
               if (!stall) begin
                  if ((cnt_q + 7'd1) < n_q) begin
                     cnt_d      = cnt_q + 7'd1;
                     mem_a_d    = base_q + {25'b0, cnt_q} + 32'd1;
                     mem_dout_d = get_byte(wdata_q, cnt_q[1:0] + 2'd1);
                  end else begin
                     wr_d       = 1'b0;
                     lsb_done_d = 1'b1;
                     state_d    = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         n_q          <= '0;
         base_q       <= '0;
         wdata_q      <= '0;
         mem_a_q      <= '0;
         mem_dout_q   <= '0;
         wr_q         <= 1'b0;
         if_done_q    <= 1'b0;
         lsb_done_q   <= 1'b0;
         if_data_q    <= '0;
         lsb_r_data_q <= '0;
         buf_q        <= '0;
         rd_vld_q     <= 1'b0;
         rd_idx_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         n_q          <= n_d;
         base_q       <= base_d;
         wdata_q      <= wdata_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         wr_q         <= wr_d;
         if_done_q    <= if_done_d;
         lsb_done_q   <= lsb_done_d;
         if_data_q    <= if_data_d;
         lsb_r_data_q <= lsb_r_data_d;
         buf_q        <= buf_d;
         rd_vld_q     <= rd_vld_d;
         rd_idx_q     <= rd_idx_d;
      end
   end

   assign mem_a      = mem_a_q;
   assign mem_dout   = mem_dout_q;
   assign mem_wr     = wr_q & rdy & ~stall;
   assign if_done    = if_done_q;
   assign if_data    = if_data_q;
   assign lsb_done   = lsb_done_q;
   assign lsb_r_data = lsb_r_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a transaction-level model predicts writes and done events.
// Build with MEM_CTRL_IO_STALL_EN to expect IO-window store stalls.
module tb_mem_ctrl;

   localparam int RamBytes = 1 << 18;

   logic         clk = 1'b0;
   logic         rst, rdy, rollback;
   logic [7:0]   mem_din, mem_dout;
   logic [31:0]  mem_a;
   logic         mem_wr, io_buffer_full;
   logic         if_en, if_done;
   logic [31:0]  if_pc;
   logic [511:0] if_data;
   logic         lsb_en, lsb_wr, lsb_done;
   logic [31:0]  lsb_addr, lsb_w_data, lsb_r_data;
   logic [2:0]   lsb_len;

   mem_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .rollback      (rollback),
      .mem_din       (mem_din),
      .mem_dout      (mem_dout),
      .mem_a         (mem_a),
      .mem_wr        (mem_wr),
      .io_buffer_full(io_buffer_full),
      .if_en         (if_en),
      .if_pc         (if_pc),
      .if_done       (if_done),
      .if_data       (if_data),
      .lsb_en        (lsb_en),
      .lsb_wr        (lsb_wr),
      .lsb_addr      (lsb_addr),
      .lsb_len       (lsb_len),
      .lsb_w_data    (lsb_w_data),
      .lsb_done      (lsb_done),
      .lsb_r_data    (lsb_r_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Physical RAM seen by the DUT, and the model's own view of memory.
   logic [7:0] ram     [RamBytes];
   logic [7:0] ref_ram [RamBytes];

   always @(posedge clk) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
   end

   typedef struct {
      bit           is_fetch;
      logic [511:0] data;
      int           cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_t;

   resp_t        resp_q[$];
   wr_t          wr_q[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  last_load = '0;
   logic [511:0] last_line = '0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mdl_load(input logic [31:0] addr, input int n);
      logic [31:0] v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_ram[int'(addr[17:0]) + k];
      return v;
   endfunction

   function automatic logic [511:0] mdl_line(input logic [31:0] pc);
      logic [511:0] v;
      for (int k = 0; k < 64; k++) v[8*k +: 8] = ref_ram[int'(pc[17:0]) + k];
      return v;
   endfunction

   // Cycle in which step a of a transfer accepted in cycle t happens, given a rdy-low
   // window of m cycles before step 1+j and an IO hold of s cycles before step 1.
   function automatic int act_cyc(input int t, input int a, input int j, input int m,
                                  input int s);
      return t + a + ((a >= 1 + j) ? m : 0) + ((a >= 1) ? s : 0);
   endfunction

   task automatic push_resp(input bit f, input logic [511:0] d, input int c);
      resp_t r;
      r.is_fetch = f;
      r.data     = d;
      r.cyc      = c;
      resp_q.push_back(r);
   endtask

   always @(negedge clk) begin : monitor
      resp_t r;
      wr_t   w;
      if (!rst) begin
         if (if_done || lsb_done) begin
            if (resp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done @cyc %0d: got if_done=%b lsb_done=%b want none",
                        cyc, if_done, lsb_done);
            end else begin
               r = resp_q.pop_front();
               chk("done_kind", 512'({if_done, lsb_done}), 512'(r.is_fetch ? 2'b10 : 2'b01));
               chk("done_cycle", 512'(cyc), 512'(r.cyc));
               if (r.is_fetch) chk("if_data", if_data, r.data);
               else            chk("lsb_r_data", 512'(lsb_r_data), r.data);
            end
         end
         if (mem_wr) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_wr @cyc %0d: got addr=%0h data=%0h want no write",
                        cyc, mem_a, mem_dout);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", 512'(mem_a), 512'(w.addr));
               chk("wr_data", 512'(mem_dout), 512'(w.data));
               chk("wr_cycle", 512'(cyc), 512'(w.cyc));
            end
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst_mem_a", 512'(mem_a), '0);
      chk("rst_mem_dout", 512'(mem_dout), '0);
      chk("rst_mem_wr", 512'(mem_wr), '0);
      chk("rst_if_done", 512'(if_done), '0);
      chk("rst_lsb_done", 512'(lsb_done), '0);
      chk("rst_if_data", if_data, '0);
      chk("rst_lsb_r_data", 512'(lsb_r_data), '0);
   endtask

   task automatic do_xfer(input bit is_fetch, input bit wr, input logic [31:0] addr,
                          input int n, input logic [31:0] wdata, input int frz_j,
                          input int frz_m, input int io_m, input int rb_off);
      int  t, done_c, s;
      wr_t w;
      t = cyc;
      s = 0;
`ifdef MEM_CTRL_IO_STALL_EN
      if (wr && addr[17:16] == 2'b11) s = io_m;
`endif
      if (is_fetch) begin
         if_en     = 1'b1;
         if_pc     = addr;
         last_line = mdl_line(addr);
         done_c    = act_cyc(t, 2 + n, frz_j, frz_m, s);
         push_resp(1'b1, last_line, done_c);
      end else begin
         lsb_en     = 1'b1;
         lsb_wr     = wr;
         lsb_addr   = addr;
         lsb_len    = 3'(n);
         lsb_w_data = wdata;
         if (wr) begin
            for (int k = 0; k < n; k++) begin
               w.addr = addr + 32'(k);
               w.data = wdata[8*k +: 8];
               w.cyc  = act_cyc(t, 1 + k, frz_j, frz_m, s);
               wr_q.push_back(w);
               ref_ram[int'(addr[17:0]) + k] = wdata[8*k +: 8];
            end
            done_c = act_cyc(t, 1 + n, frz_j, frz_m, s);
            push_resp(1'b0, 512'(last_load), done_c);
         end else begin
            last_load = mdl_load(addr, n);
            done_c    = act_cyc(t, 2 + n, frz_j, frz_m, s);
            push_resp(1'b0, 512'(last_load), done_c);
         end
      end
      tick();
      // Requests are latched at acceptance; scramble the inputs afterwards.
      if_en      = 1'b0;
      lsb_en     = 1'b0;
      if_pc      = $urandom;
      lsb_addr   = $urandom;
      lsb_w_data = $urandom;
      lsb_len    = 3'($urandom);
      lsb_wr     = 1'($urandom);
      while (cyc < done_c) begin
         if (frz_m == 0 && io_m == 0 && cyc <= t + n)
            chk("mem_a", 512'(mem_a), 512'(addr + 32'(cyc - t - 1)));
         rdy            = !(cyc >= t + 1 + frz_j && cyc <= t + frz_j + frz_m);
         io_buffer_full = (cyc >= t + 1 && cyc <= t + io_m);
         rollback       = (cyc == t + rb_off);
         tick();
      end
      rdy            = 1'b1;
      io_buffer_full = 1'b0;
      rollback       = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
   endtask

   initial begin
      int t, seen, kind, n, nn, j, m, rb;
      logic [31:0] addr;

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      if_en = 1'b0; if_pc = '0; lsb_en = 1'b0; lsb_wr = 1'b0;
      lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
      for (int i = 0; i < RamBytes; i++) begin
         ram[i]     = 8'($urandom);
         ref_ram[i] = ram[i];
      end
      for (int k = 0; k < 64; k++) begin
         ram[32'h40 + k]     = 8'(k);
         ref_ram[32'h40 + k] = 8'(k);
      end
      for (int k = 0; k < 4; k++) begin
         ram[32'h100 + k]     = 8'(8'h11 * (k + 1));
         ref_ram[32'h100 + k] = 8'(8'h11 * (k + 1));
      end
      repeat (3) tick();
      rst = 1'b0;
      check_reset_outputs();
      tick();

      // Directed fetch, load and store.
      do_xfer(1'b1, 1'b0, 32'h40, 64, '0, 0, 0, 0, -1);
      do_xfer(1'b0, 1'b0, 32'h100, 4, '0, 0, 0, 0, -1);
      chk("load_0x100", 512'(last_load), 512'(32'h4433_2211));
      do_xfer(1'b0, 1'b1, 32'h200, 2, 32'hDEAD_BEEF, 0, 0, 0, -1);

      // Load and fetch requested together: load first, fetch one idle cycle after done.
      t = cyc;
      if_en = 1'b1; if_pc = 32'h1C0;
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h300; lsb_len = 3'd4;
      last_load = mdl_load(32'h300, 4);
      push_resp(1'b0, 512'(last_load), t + 6);
      last_line = mdl_line(32'h1C0);
      push_resp(1'b1, last_line, t + 7 + 66);
      tick();
      lsb_en = 1'b0;
      while (cyc <= t + 7) tick();
      if_en = 1'b0;
      if_pc = $urandom;
      while (cyc < t + 73) tick();
      repeat (2) tick();

      // Rollback during a fetch aborts it silently.
      t = cyc;
      if_en = 1'b1; if_pc = 32'h800;
      tick();
      if_en = 1'b0;
      while (cyc < t + 10) tick();
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      seen = 0;
      repeat (70) begin
         if (if_done) seen++;
         tick();
      end
      chk("rollback_no_done", 512'(seen), '0);
      chk("rollback_if_data_held", if_data, last_line);

      // Store to the IO window while the UART buffer is full.
      do_xfer(1'b0, 1'b1, 32'h3_0000, 1, 32'h0000_005A, 0, 0, 5, -1);

      repeat (40) begin
         kind = $urandom_range(0, 2);
         n    = 1 << $urandom_range(0, 2);
         nn   = (kind == 0) ? 64 : n;
         if (kind == 0) addr = 32'($urandom_range(0, 4094)) << 6;
         else           addr = 32'($urandom_range(0, RamBytes - 8));
         if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(0, nn - 1);
            m = $urandom_range(1, 4);
         end else begin
            j = 0;
            m = 0;
         end
         rb = (kind == 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : -1;
         do_xfer(kind == 0, kind == 2, addr, nn, $urandom, j, m, 0, rb);
      end

      // Reset in the middle of a load, with rdy low, aborts with no done.
      t = cyc;
      lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h500; lsb_len = 3'd4;
      tick();
      lsb_en = 1'b0;
      while (cyc < t + 3) tick();
      rst = 1'b1;
      rdy = 1'b0;
      tick();
      rst = 1'b0;
      rdy = 1'b1;
      check_reset_outputs();
      repeat (10) tick();

      chk("resp_q_drained", 512'(resp_q.size()), '0);
      chk("wr_q_drained", 512'(wr_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
